// File: rtl/mmio_timer_responder.sv
// Memory-mapped prescaled timer (CTRL/COUNT/COMPARE/STATUS) on the CPU data bus, one-cycle read latency.
// Optional build macro TIMER_AUTORELOAD_EN: a compare match reloads COUNT to zero (periodic mode).
module mmio_timer_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
    parameter int          PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        wr,
    input  logic [31:0] datain,
    output logic [31:0] dataout,
    output logic        hit,
    output logic        irq
);
    localparam logic [1:0] IDX_CTRL    = 2'd0;
    localparam logic [1:0] IDX_COUNT   = 2'd1;
    localparam logic [1:0] IDX_COMPARE = 2'd2;
    localparam logic [1:0] IDX_STATUS  = 2'd3;

    logic                  sel_s;
    logic [1:0]            idx_s;
    logic                  rd_s;
    logic                  wr_ctrl_s;
    logic                  wr_count_s;
    logic                  wr_compare_s;
    logic                  wr_status_s;
    logic                  en_r;
    logic                  irq_en_r;
    logic [PRESCALE_W-1:0] psc_r;
    logic [PRESCALE_W-1:0] prescaler_r;
    logic [PRESCALE_W-1:0] prescaler_next_s;
    logic [31:0]           count_r;
    logic [31:0]           compare_r;
    logic                  match_r;
    logic                  ovf_r;
    logic                  tick_s;
    logic [31:0]           count_inc_s;
    logic [31:0]           count_next_s;
    logic                  match_set_s;
    logic                  ovf_set_s;
    logic [31:0]           rdata_s;
    logic                  unused_s;

    // Byte-lane bits carry no meaning for word registers.
    assign unused_s = ^address[1:0];

    // Window decode and per-register strobes.
    always_comb begin
        sel_s        = (address[31:4] == BASE_ADDR[31:4]);
        idx_s        = address[3:2];
        rd_s         = sel_s & ~wr;
        wr_ctrl_s    = sel_s & wr & (idx_s == IDX_CTRL);
        wr_count_s   = sel_s & wr & (idx_s == IDX_COUNT);
        wr_compare_s = sel_s & wr & (idx_s == IDX_COMPARE);
        wr_status_s  = sel_s & wr & (idx_s == IDX_STATUS);
    end

    // Counter step and flag events; a CPU write to COUNT swallows a coincident tick.
    always_comb begin
        tick_s       = en_r & (prescaler_r == psc_r);
        count_inc_s  = count_r + 32'd1;
        match_set_s  = 1'b0;
        ovf_set_s    = 1'b0;
        count_next_s = count_r;
        if (wr_count_s) begin
            count_next_s = datain;
        end else if (tick_s) begin
            match_set_s = (count_inc_s == compare_r);
            ovf_set_s   = (count_r == 32'hFFFF_FFFF);
`ifdef TIMER_AUTORELOAD_EN
            count_next_s = match_set_s ? 32'd0 : count_inc_s;
`else
            count_next_s = count_inc_s;
`endif
        end else begin
            count_next_s = count_r;
        end
    end

    // Prescaler restarts on COUNT writes, on disable, and after each tick.
    always_comb begin
        if (wr_count_s) begin
            prescaler_next_s = '0;
        end else if (wr_ctrl_s && en_r && !datain[0]) begin
            prescaler_next_s = '0;
        end else if (!en_r || tick_s) begin
            prescaler_next_s = '0;
        end else begin
            prescaler_next_s = prescaler_r + PRESCALE_W'(1);
        end
    end

    // Read mux; unimplemented bits read as zero.
    always_comb begin
        rdata_s = 32'd0;
        case (idx_s)
            IDX_CTRL: begin
                rdata_s[0]               = en_r;
                rdata_s[1]               = irq_en_r;
                rdata_s[8 +: PRESCALE_W] = psc_r;
            end
            IDX_COUNT:   rdata_s = count_r;
            IDX_COMPARE: rdata_s = compare_r;
            IDX_STATUS:  rdata_s = {30'd0, ovf_r, match_r};
            default:     rdata_s = 32'd0;
        endcase
    end

    // Control, counter, compare and prescaler state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_r        <= 1'b0;
            irq_en_r    <= 1'b0;
            psc_r       <= '0;
            prescaler_r <= '0;
            count_r     <= 32'd0;
            compare_r   <= 32'd0;
        end else begin
            if (wr_ctrl_s) begin
                en_r     <= datain[0];
                irq_en_r <= datain[1];
                psc_r    <= datain[8 +: PRESCALE_W];
            end
            if (wr_compare_s) begin
                compare_r <= datain;
            end
            prescaler_r <= prescaler_next_s;
            count_r     <= count_next_s;
        end
    end

    // Sticky flags: a same-cycle set beats write-1-to-clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            match_r <= match_set_s | (match_r & ~(wr_status_s & datain[0]));
            ovf_r   <= ovf_set_s   | (ovf_r   & ~(wr_status_s & datain[1]));
        end
    end

    // Registered read response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataout <= 32'd0;
            hit     <= 1'b0;
        end else begin
            dataout <= rd_s ? rdata_s : 32'd0;
            hit     <= rd_s;
        end
    end

    assign irq = match_r & irq_en_r;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Bench for mmio_timer_responder: per-cycle comparison against a register-level model plus directed literal checks.
module tb_mmio_timer_responder;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic        wr;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic        hit;
    logic        irq;
    logic        run_cmp = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    mmio_timer_responder #(.BASE_ADDR(BASE), .PRESCALE_W(8)) dut (
        .clk(clk), .reset(reset), .address(address), .wr(wr),
        .datain(datain), .dataout(dataout), .hit(hit), .irq(irq)
    );

    typedef struct packed {
        logic        en;
        logic        irqen;
        logic [7:0]  psc;
        logic [31:0] count;
        logic [31:0] compare;
        logic        match;
        logic        ovf;
        logic [31:0] elapsed;   // enabled cycles since the prescale period last restarted
        logic [31:0] rdata;
        logic        hit;
    } mstate_t;

    mstate_t m;

    function automatic logic [31:0] reg_view(input mstate_t s, input logic [1:0] idx);
        case (idx)
            2'd0:    return {16'd0, s.psc, 6'd0, s.irqen, s.en};
            2'd1:    return s.count;
            2'd2:    return s.compare;
            default: return {30'd0, s.ovf, s.match};
        endcase
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic [31:0] a,
                                           input logic w, input logic [31:0] d);
        mstate_t     n;
        logic        sel;
        logic [1:0]  idx;
        logic        tick;
        logic        count_written;
        logic [31:0] nxt;
        logic [31:0] period;
        n      = s;
        sel    = ((a >> 4) == (BASE >> 4));
        idx    = a[3:2];
        period = {24'd0, s.psc} + 32'd1;
        tick   = s.en && ((s.elapsed % period) == {24'd0, s.psc});
        n.hit   = sel && !w;
        n.rdata = n.hit ? reg_view(s, idx) : 32'd0;
        count_written = sel && w && (idx == 2'd1);
        if (sel && w) begin
            case (idx)
                2'd0: begin n.en = d[0]; n.irqen = d[1]; n.psc = d[15:8]; end
                2'd1: n.count = d;
                2'd2: n.compare = d;
                default: begin
                    if (d[0]) n.match = 1'b0;
                    if (d[1]) n.ovf = 1'b0;
                end
            endcase
        end
        if (tick && !count_written) begin
            nxt = s.count + 32'd1;
            if (nxt == s.compare) n.match = 1'b1;
            if (s.count == 32'hFFFF_FFFF) n.ovf = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
            n.count = (nxt == s.compare) ? 32'd0 : nxt;
`else
            n.count = nxt;
`endif
        end
        if (count_written || !s.en || (sel && w && idx == 2'd0 && !d[0]))
            n.elapsed = 32'd0;
        else
            n.elapsed = s.elapsed + 32'd1;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '0;
        else        m <= model_next(m, address, wr, datain);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            check("cyc_dataout", dataout, m.rdata);
            check("cyc_hit", {31'd0, hit}, {31'd0, m.hit});
            check("cyc_irq", {31'd0, irq}, {31'd0, m.match & m.irqen});
        end
    end

    task automatic idle();
        address = 32'd0;
        wr      = 1'b0;
        datain  = 32'd0;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic write_reg(input logic [1:0] idx, input logic [31:0] val);
        address = BASE + {28'd0, idx, 2'b00};
        wr      = 1'b1;
        datain  = val;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic read_addr(input logic [31:0] a, output logic [31:0] d, output logic h);
        address = a;
        wr      = 1'b0;
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        d = dataout;
        h = hit;
        @(posedge clk); #1;
    endtask

    task automatic read_reg(input logic [1:0] idx, output logic [31:0] d, output logic h);
        read_addr(BASE + {28'd0, idx, 2'b00}, d, h);
    endtask

    logic [31:0] d;
    logic        h;
    logic [31:0] exp_v;

    initial begin
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        run_cmp = 1'b1;
        @(negedge clk);
        check("rst_dataout", dataout, 32'd0);
        check("rst_hit", {31'd0, hit}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        read_addr(BASE + 32'd4, d, h);
        check("rd_count0", d, 32'd0);
        check("rd_count0_hit", {31'd0, h}, 32'd1);
        read_addr(32'h0000_0200, d, h);
        check("rd_outside", d, 32'd0);
        check("rd_outside_hit", {31'd0, h}, 32'd0);

        // psc=2: a COUNT step every 3 cycles, so COUNT reaches 5 on the 15th edge
        write_reg(2'd2, 32'd5);
        write_reg(2'd0, 32'h0000_0203);
        cyc(14);
        read_reg(2'd1, d, h);
        check("psc_count_before_15", d, 32'd4);
        read_reg(2'd1, d, h);
`ifdef TIMER_AUTORELOAD_EN
        check("psc_count_at_15", d, 32'd0);
`else
        check("psc_count_at_15", d, 32'd5);
`endif
        read_reg(2'd3, d, h);
        check("match_status", d, 32'd1);
        check("match_irq", {31'd0, irq}, 32'd1);
        write_reg(2'd3, 32'd1);
        @(negedge clk);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        write_reg(2'd0, 32'd0);

        // overflow across 2^32
        write_reg(2'd1, 32'hFFFF_FFFE);
        write_reg(2'd0, 32'd1);
        cyc(1);
        write_reg(2'd0, 32'd0);
        read_reg(2'd1, d, h);
        check("ovf_count_wrapped", d, 32'd0);
        read_reg(2'd3, d, h);
        check("ovf_status", d, 32'd2);
        write_reg(2'd3, 32'd3);

        // COUNT write in a tick cycle beats the tick
        write_reg(2'd0, 32'd1);
        write_reg(2'd1, 32'd100);
        read_reg(2'd1, d, h);
        check("count_write_wins", d, 32'd100);
        write_reg(2'd0, 32'd0);

        // W1C in the same cycle the match sets: set wins
        write_reg(2'd1, 32'd10);
        write_reg(2'd2, 32'd12);
        write_reg(2'd3, 32'd3);
        write_reg(2'd0, 32'd1);
        cyc(1);
        write_reg(2'd3, 32'd1);
        write_reg(2'd0, 32'd0);
        read_reg(2'd3, d, h);
        check("w1c_vs_set", d, 32'd1);
        read_reg(2'd1, d, h);
`ifdef TIMER_AUTORELOAD_EN
        check("w1c_count", d, 32'd1);
`else
        check("w1c_count", d, 32'd13);
`endif

        // free-running vs periodic sequence with COMPARE=3, psc=0
        write_reg(2'd2, 32'd3);
        write_reg(2'd1, 32'd0);
        write_reg(2'd3, 32'd3);
        write_reg(2'd0, 32'd1);
        address = BASE + 32'd4;
        wr      = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
`ifdef TIMER_AUTORELOAD_EN
            exp_v = k % 3;
`else
            exp_v = k;
`endif
            check("seq_count", dataout, exp_v);
        end
        @(posedge clk); #1;
        idle();
        write_reg(2'd0, 32'd3);
        read_reg(2'd3, d, h);
        check("seq_match", d, 32'd1);
        check("seq_irq", {31'd0, irq}, 32'd1);

        // reset in the middle of operation with a read in flight
        write_reg(2'd1, 32'd7);
        address = BASE + 32'd4;
        wr      = 1'b0;
        @(posedge clk); #1;
        idle();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_hit", {31'd0, hit}, 32'd0);
        check("midrst_dataout", dataout, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int r = 0; r < 4; r++) begin
            read_reg(r[1:0], d, h);
            check("midrst_reg", d, 32'd0);
        end
        check("midrst_irq_after", {31'd0, irq}, 32'd0);

        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
